// File: rtl/dfp_align128_if.sv
// Operand and result bundle for the DFP128 pre-add alignment stage.
// The producer/consumer side uses master; the aligner uses slave.
interface dfp_align128_if #(parameter int N = 34);
    logic               vld_i;
    logic               a_sign;
    logic               b_sign;
    logic [13:0]        a_exp;
    logic [13:0]        b_exp;
    logic [N*4-1:0]     a_sig;
    logic [N*4-1:0]     b_sig;
    logic               a_nan;
    logic               b_nan;
    logic               a_inf;
    logic               b_inf;

    logic               vld_o;
    logic               swap_o;
    logic [13:0]        exp_o;
    logic               big_sign_o;
    logic               sml_sign_o;
    logic [(N+2)*4-1:0] big_sig_o;
    logic [(N+2)*4-1:0] sml_sig_o;
    logic               sticky_o;
    logic               nan_o;
    logic               inf_o;

    modport master (
        output vld_i, a_sign, b_sign, a_exp, b_exp, a_sig, b_sig,
               a_nan, b_nan, a_inf, b_inf,
        input  vld_o, swap_o, exp_o, big_sign_o, sml_sign_o,
               big_sig_o, sml_sig_o, sticky_o, nan_o, inf_o
    );

    modport slave (
        input  vld_i, a_sign, b_sign, a_exp, b_exp, a_sig, b_sig,
               a_nan, b_nan, a_inf, b_inf,
        output vld_o, swap_o, exp_o, big_sign_o, sml_sign_o,
               big_sig_o, sml_sig_o, sticky_o, nan_o, inf_o
    );
endinterface

// File: rtl/dfp_align128.sv
// Four-stage pre-add aligner: orders operands by exponent and right-shifts
// the smaller BCD significand by whole digits, producing guard/round/sticky.
module dfp_align128 #(
    parameter int N = 34
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    dfp_align128_if.slave   bus
);
    localparam int SW = N * 4;
    localparam int W  = (N + 2) * 4;

    logic           s1_vld, s1_a_sign, s1_b_sign, s1_nan, s1_inf, s1_gt;
    logic [13:0]    s1_a_exp, s1_b_exp, s1_diff;
    logic [SW-1:0]  s1_a_sig, s1_b_sig;
    logic           gt_c;
    logic [13:0]    diff_c;

    assign gt_c   = bus.b_exp > bus.a_exp;
    assign diff_c = gt_c ? (bus.b_exp - bus.a_exp) : (bus.a_exp - bus.b_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_a_sign <= 1'b0;
            s1_b_sign <= 1'b0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_gt     <= 1'b0;
            s1_a_exp  <= '0;
            s1_b_exp  <= '0;
            s1_diff   <= '0;
            s1_a_sig  <= '0;
            s1_b_sig  <= '0;
        end else if (ce) begin
            s1_vld    <= bus.vld_i;
            s1_a_sign <= bus.a_sign;
            s1_b_sign <= bus.b_sign;
            s1_nan    <= bus.a_nan | bus.b_nan;
            s1_inf    <= bus.a_inf | bus.b_inf;
            s1_gt     <= gt_c;
            s1_a_exp  <= bus.a_exp;
            s1_b_exp  <= bus.b_exp;
            s1_diff   <= diff_c;
            s1_a_sig  <= bus.a_sig;
            s1_b_sig  <= bus.b_sig;
        end
    end

    // Any difference of N+2 digits or more pushes the whole significand below the round digit.
    logic           s2_vld, s2_swap, s2_big_sign, s2_sml_sign, s2_nan, s2_inf;
    logic [13:0]    s2_exp;
    logic [W-1:0]   s2_big_ext, s2_sml_ext;
    logic [5:0]     s2_shift;
    logic [5:0]     shift_c;

    assign shift_c = (s1_diff >= 14'(N + 2)) ? 6'(N + 2) : s1_diff[5:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld      <= 1'b0;
            s2_swap     <= 1'b0;
            s2_big_sign <= 1'b0;
            s2_sml_sign <= 1'b0;
            s2_nan      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_exp      <= '0;
            s2_big_ext  <= '0;
            s2_sml_ext  <= '0;
            s2_shift    <= '0;
        end else if (ce) begin
            s2_vld      <= s1_vld;
            s2_swap     <= s1_gt;
            s2_big_sign <= s1_gt ? s1_b_sign : s1_a_sign;
            s2_sml_sign <= s1_gt ? s1_a_sign : s1_b_sign;
            s2_nan      <= s1_nan;
            s2_inf      <= s1_inf;
            s2_exp      <= s1_gt ? s1_b_exp : s1_a_exp;
            s2_big_ext  <= s1_gt ? {s1_b_sig, 8'h00} : {s1_a_sig, 8'h00};
            s2_sml_ext  <= s1_gt ? {s1_a_sig, 8'h00} : {s1_b_sig, 8'h00};
            s2_shift    <= shift_c;
        end
    end

    logic           s3_vld, s3_swap, s3_big_sign, s3_sml_sign, s3_nan, s3_inf, s3_sticky;
    logic [13:0]    s3_exp;
    logic [W-1:0]   s3_big_sig, s3_sml_sig;
    logic [7:0]     sh_bits;
    logic [W-1:0]   sml_sh_c, lost_mask;
    logic           sticky_c;

    assign sh_bits   = {s2_shift, 2'b00};
    assign sml_sh_c  = s2_sml_ext >> sh_bits;
    assign lost_mask = ~({W{1'b1}} << sh_bits);
    assign sticky_c  = |(s2_sml_ext & lost_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_vld      <= 1'b0;
            s3_swap     <= 1'b0;
            s3_big_sign <= 1'b0;
            s3_sml_sign <= 1'b0;
            s3_nan      <= 1'b0;
            s3_inf      <= 1'b0;
            s3_sticky   <= 1'b0;
            s3_exp      <= '0;
            s3_big_sig  <= '0;
            s3_sml_sig  <= '0;
        end else if (ce) begin
            s3_vld      <= s2_vld;
            s3_swap     <= s2_swap;
            s3_big_sign <= s2_big_sign;
            s3_sml_sign <= s2_sml_sign;
            s3_nan      <= s2_nan;
            s3_inf      <= s2_inf;
            s3_sticky   <= sticky_c;
            s3_exp      <= s2_exp;
            s3_big_sig  <= s2_big_ext;
            s3_sml_sig  <= sml_sh_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vld_o      <= 1'b0;
            bus.swap_o     <= 1'b0;
            bus.big_sign_o <= 1'b0;
            bus.sml_sign_o <= 1'b0;
            bus.nan_o      <= 1'b0;
            bus.inf_o      <= 1'b0;
            bus.sticky_o   <= 1'b0;
            bus.exp_o      <= '0;
            bus.big_sig_o  <= '0;
            bus.sml_sig_o  <= '0;
        end else if (ce) begin
            bus.vld_o      <= s3_vld;
            bus.swap_o     <= s3_swap;
            bus.big_sign_o <= s3_big_sign;
            bus.sml_sign_o <= s3_sml_sign;
            bus.nan_o      <= s3_nan;
            bus.inf_o      <= s3_inf;
            bus.sticky_o   <= s3_sticky;
            bus.exp_o      <= s3_exp;
            bus.big_sig_o  <= s3_big_sig;
            bus.sml_sig_o  <= s3_sml_sig;
        end
    end
endmodule

// File: tb/tb_dfp_align128.sv
// Scoreboard bench for dfp_align128: directed operand pairs push hand-computed
// results; a negedge monitor pops and compares whenever vld_o is presented.
module tb_dfp_align128;
    localparam int N  = 34;
    localparam int SW = N * 4;
    localparam int W  = (N + 2) * 4;

    typedef struct packed {
        logic          a_sign, b_sign;
        logic [13:0]   a_exp, b_exp;
        logic [SW-1:0] a_sig, b_sig;
        logic          a_nan, b_nan, a_inf, b_inf;
    } in_t;

    typedef struct packed {
        logic          chk_data;
        logic          swap;
        logic [13:0]   exp;
        logic          big_sign, sml_sign;
        logic [W-1:0]  big_sig, sml_sig;
        logic          sticky, nan, inf;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    expect_t exp_q[$];
    expect_t last_e;
    logic have_last = 1'b0;
    logic prev_ce   = 1'b0;

    dfp_align128_if #(.N(N)) bus ();

    dfp_align128 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic as, logic bs, logic [13:0] ae, logic [13:0] be,
                                  logic [SW-1:0] asg, logic [SW-1:0] bsg,
                                  logic an, logic bn, logic ai, logic bi);
        in_t s;
        s = '{a_sign:as, b_sign:bs, a_exp:ae, b_exp:be, a_sig:asg, b_sig:bsg,
              a_nan:an, b_nan:bn, a_inf:ai, b_inf:bi};
        return s;
    endfunction

    function automatic expect_t mk_exp(logic cd, logic sw, logic [13:0] ex, logic bsn, logic ssn,
                                       logic [W-1:0] bsig, logic [W-1:0] ssig,
                                       logic st, logic na, logic nf);
        expect_t e;
        e = '{chk_data:cd, swap:sw, exp:ex, big_sign:bsn, sml_sign:ssn,
              big_sig:bsig, sml_sig:ssig, sticky:st, nan:na, inf:nf};
        return e;
    endfunction

    task automatic checkField(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        if (e.chk_data) begin
            checkField("swap_o", W'(bus.swap_o), W'(e.swap));
            checkField("exp_o", W'(bus.exp_o), W'(e.exp));
            checkField("big_sign_o", W'(bus.big_sign_o), W'(e.big_sign));
            checkField("sml_sign_o", W'(bus.sml_sign_o), W'(e.sml_sign));
            checkField("big_sig_o", bus.big_sig_o, e.big_sig);
            checkField("sml_sig_o", bus.sml_sig_o, e.sml_sig);
            checkField("sticky_o", W'(bus.sticky_o), W'(e.sticky));
        end
        checkField("nan_o", W'(bus.nan_o), W'(e.nan));
        checkField("inf_o", W'(bus.inf_o), W'(e.inf));
    endtask

    task automatic checkReset(input string tag);
        $display("[TB] reset state check: %s", tag);
        checkField("rst_vld_o", W'(bus.vld_o), '0);
        checkField("rst_swap_o", W'(bus.swap_o), '0);
        checkField("rst_exp_o", W'(bus.exp_o), '0);
        checkField("rst_signs", W'({bus.big_sign_o, bus.sml_sign_o}), '0);
        checkField("rst_big_sig_o", bus.big_sig_o, '0);
        checkField("rst_sml_sig_o", bus.sml_sig_o, '0);
        checkField("rst_flags", W'({bus.sticky_o, bus.nan_o, bus.inf_o}), '0);
    endtask

    task automatic applyStimulus(input logic vld, input in_t s, input expect_t e);
        bus.vld_i  = vld;
        bus.a_sign = s.a_sign;
        bus.b_sign = s.b_sign;
        bus.a_exp  = s.a_exp;
        bus.b_exp  = s.b_exp;
        bus.a_sig  = s.a_sig;
        bus.b_sig  = s.b_sig;
        bus.a_nan  = s.a_nan;
        bus.b_nan  = s.b_nan;
        bus.a_inf  = s.a_inf;
        bus.b_inf  = s.b_inf;
        if (vld && ce && !rst) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0);
    endtask

    // ce seen at one negedge governs the following posedge, so it is remembered for the next sample.
    always @(negedge clk) begin
        if (bus.vld_o && prev_ce) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_vld_o actual=1 required=0");
            end else begin
                last_e    = exp_q.pop_front();
                have_last = 1'b1;
                checkOutput(last_e);
            end
        end else if (bus.vld_o && !prev_ce && have_last) begin
            checkOutput(last_e);
        end
        prev_ce = ce;
    end

    initial begin
        bus.vld_i = 1'b0;
        bus.a_sign = 1'b0; bus.b_sign = 1'b0;
        bus.a_exp = '0; bus.b_exp = '0; bus.a_sig = '0; bus.b_sig = '0;
        bus.a_nan = 1'b0; bus.b_nan = 1'b0; bus.a_inf = 1'b0; bus.b_inf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("power-on");
        rst = 1'b0;

        // Equal exponents, shift by 2 and 3 (swapped), full flush, and the 35/36 digit boundary.
        applyStimulus(1'b1, mk_in(0, 1, 14'h17C0, 14'h17C0, SW'(1), SW'(9), 0, 0, 0, 0),
                      mk_exp(1, 0, 14'h17C0, 0, 1, W'(12'h100), W'(12'h900), 0, 0, 0));
        applyStimulus(1'b1, mk_in(1, 0, 14'h17C0, 14'h17C2, SW'(12'h123), SW'(4'h5) << (SW-4), 0, 0, 0, 0),
                      mk_exp(1, 1, 14'h17C2, 0, 1, W'(4'h5) << (W-4), W'(12'h123), 0, 0, 0));
        applyStimulus(1'b1, mk_in(1, 0, 14'h17C0, 14'h17C3, SW'(12'h123), SW'(4'h5) << (SW-4), 0, 0, 0, 0),
                      mk_exp(1, 1, 14'h17C3, 0, 1, W'(4'h5) << (W-4), W'(8'h12), 1, 0, 0));
        idle(1);
        applyStimulus(1'b1, mk_in(0, 0, 14'd200, 14'd100, SW'(4), SW'(1), 0, 0, 0, 0),
                      mk_exp(1, 0, 14'd200, 0, 0, W'(12'h400), '0, 1, 0, 0));
        applyStimulus(1'b1, mk_in(0, 1, 14'd200, 14'd100, SW'(4), SW'(0), 0, 0, 0, 0),
                      mk_exp(1, 0, 14'd200, 0, 1, W'(12'h400), '0, 0, 0, 0));
        applyStimulus(1'b1, mk_in(0, 0, 14'd35, 14'd0, SW'(2), SW'(4'h7) << (SW-4), 0, 0, 0, 0),
                      mk_exp(1, 0, 14'd35, 0, 0, W'(12'h200), W'(4'h7), 0, 0, 0));
        applyStimulus(1'b1, mk_in(0, 0, 14'd36, 14'd0, SW'(2), SW'(4'h7) << (SW-4), 0, 0, 0, 0),
                      mk_exp(1, 0, 14'd36, 0, 0, W'(12'h200), '0, 1, 0, 0));
        applyStimulus(1'b1, mk_in(0, 0, 14'h3000, 14'h0010, SW'(7), SW'(3), 1, 0, 0, 0),
                      mk_exp(0, 0, 14'h0, 0, 0, '0, '0, 0, 1, 0));
        applyStimulus(1'b1, mk_in(0, 0, 14'h0010, 14'h0020, SW'(7), SW'(3), 0, 0, 0, 1),
                      mk_exp(0, 0, 14'h0, 0, 0, '0, '0, 0, 0, 1));
        idle(6);

        $display("[TB] stall sequence");
        applyStimulus(1'b1, mk_in(0, 0, 14'd10, 14'd12, SW'(8'h45), SW'(4'h7), 0, 0, 0, 0),
                      mk_exp(1, 1, 14'd12, 0, 0, W'(12'h700), W'(8'h45), 0, 0, 0));
        applyStimulus(1'b1, mk_in(0, 1, 14'd20, 14'd19, SW'(4'h8), SW'(8'h36), 0, 0, 0, 0),
                      mk_exp(1, 0, 14'd20, 0, 1, W'(12'h800), W'(12'h360), 0, 0, 0));
        applyStimulus(1'b1, mk_in(1, 1, 14'd5, 14'd9, SW'(16'h9876), SW'(1), 0, 0, 0, 0),
                      mk_exp(1, 1, 14'd9, 1, 1, W'(12'h100), W'(8'h98), 1, 0, 0));
        idle(1);
        ce = 1'b0;
        idle(2);
        ce = 1'b1;
        idle(6);

        begin
            int waited = 0;
            while (exp_q.size() != 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            #1;
            checkField("drain_queue_empty", W'(exp_q.size()), '0);
        end

        $display("[TB] reset with operands in flight");
        applyStimulus(1'b1, mk_in(0, 0, 14'd50, 14'd40, SW'(5), SW'(6), 0, 0, 0, 0),
                      mk_exp(1, 0, 14'd50, 0, 0, W'(12'h500), '0, 1, 0, 0));
        applyStimulus(1'b1, mk_in(0, 0, 14'd60, 14'd61, SW'(5), SW'(6), 1, 0, 1, 0),
                      mk_exp(0, 0, 14'd0, 0, 0, '0, '0, 0, 1, 1));
        rst = 1'b1;
        exp_q.delete();
        idle(1);
        checkReset("mid-stream");
        rst = 1'b0;
        idle(1);
        checkField("vld_o_after_rst", W'(bus.vld_o), '0);
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dfp_align128.md
Name: dfp_align128

Overview:
- Pre-add alignment unit for the 128-bit decimal floating point adder. It is the denormalizing counterpart of the normalizer.
- Takes two unpacked DFP128 operands and orders them so the larger exponent comes first.
- Right-shifts the smaller operand's BCD significand by the exponent difference, in whole digits, and extends both significands with guard and round digits.
- Generates a sticky bit, then hands a common exponent and two aligned significands to the add/subtract stage.

Parameters:
- N, 34, significand length in BCD digits (4 bits per digit).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when low, all pipeline state holds
- vld_i  in  1  input operands valid this cycle
- a_sign, b_sign  in  1  operand signs
- a_exp, b_exp  in  14  biased exponents, unsigned
- a_sig, b_sig  in  N*4  BCD significands, leading digit at MSB
- a_nan, b_nan, a_inf, b_inf  in  1  special-value flags
- vld_o  out  1  aligned result valid
- swap_o  out  1  1 = operands were exchanged (b had the larger exponent)
- exp_o  out  14  common (larger) exponent
- big_sign_o, sml_sign_o  out  1  signs of the larger-exponent and smaller-exponent operands
- big_sig_o  out  (N+2)*4  larger operand significand, followed by two zero digits
- sml_sig_o  out  (N+2)*4  shifted smaller operand significand, including guard and round digits
- sticky_o  out  1  OR of every bit shifted below the round digit
- nan_o, inf_o  out  1  OR of the operand flags, delayed

Behaviour:
- Reset: on posedge clk with rst=1, all stage valids clear and all output registers go to 0. rst takes priority over ce. Reset in mid-pipeline discards every in-flight operand; vld_o is 0 on the cycle after reset deasserts.
- Stall: when ce=0, every stage register, including the valid bits, holds. Outputs are stable.
- Latency: exactly 4 ce-qualified cycles from vld_i to vld_o. Throughput is one operand pair per ce cycle; there is no back-pressure.
- Invalid data: it propagates through the datapath, but vld_o is low for it. Consumers ignore the data when vld_o=0.
- Stage 1: register inputs. Compute gt = (b_exp > a_exp) and diff = gt ? b_exp-a_exp : a_exp-b_exp, both 14-bit. Equal exponents give gt=0 and diff=0.
- Stage 2: swap on gt. The big operand is b when gt=1, otherwise a.
- Stage 2, shift clamp: the digit shift amount is min(diff, N+2), 6 bits. Any diff >= N+2 flushes the smaller significand completely.
- Stage 2, extension: form sml_ext = {small_sig, 8'h00}, i.e. (N+2)*4 bits. Form big_ext the same way.
- Stage 3: sml_sh = sml_ext >> (shift*4). Sticky is the OR of all sml_ext bits shifted out below bit 0. When the operand is fully flushed, sticky = |small_sig.
- Stage 4: register the outputs.
- exp_o is the larger exponent, unchanged.
- Specials: if either NaN or infinity flag is set, alignment still runs but its values are don't-care. nan_o and inf_o are delayed with the data, and downstream logic overrides the result.
- Shifts are whole BCD digits only. No binary shifts, and no digit values are modified.
- Zero significand: the smaller operand shifts to zero with sticky=0. No special handling is needed.

Test Plan:
- Equal exponents: a_exp=b_exp=0x17C0, a_sig=1 (LSD), b_sig=9 (LSD). Expected 4 cycles later:
  - swap_o=0, exp_o=0x17C0.
  - big_sig_o ends ...0001_0000_0000, sml_sig_o ends ...1001_0000_0000.
  - sticky_o=0.
- Shift by 2, swapped: a_exp=0x17C0, a_sig=0x...0123; b_exp=0x17C2, b_sig=0x5 at MSD. Expected:
  - swap_o=1, exp_o=0x17C2.
  - sml_sig_o low 12 bits = 0x123, since the shifted-out digits land exactly in the guard and round digits.
  - sticky_o=0.
- Shift by 3: same as the previous case but b_exp=0x17C3. Expected sml_sig_o low 12 bits = 0x012 and sticky_o=1, because the digit 3 was shifted past the round digit.
- Full flush: diff=100, small_sig=0x1 in the LSD. Expected sml_sig_o=0 and sticky_o=1. Repeat with small_sig=0; expected sticky_o=0.
- Stall and reset:
  - Issue 3 back-to-back valid pairs, drop ce for 2 cycles mid-stream. vld_o pattern resumes unchanged and outputs hold during the stall.
  - Assert rst with 2 pairs in flight. Expected: vld_o=0 and all outputs 0 the next cycle, and no stale result emerges afterward.
- Specials: a_nan=1 with arbitrary exponents. Expected nan_o=1 and vld_o=1 after 4 cycles. With b_inf=1, inf_o=1 with the same latency.
